// File: rtl/fp_signmag_addsub_pipe.sv
// Sign-magnitude mantissa add/subtract for the FP adder, between alignment and normalisation.
// Latency: 2 cycles (S1 compare/order, S2 add/sub + leading-zero count), one beat per cycle.
// Backpressure: out_ready low holds S2; S1 keeps its beat and in_ready drops once S1 is also full.
module fp_signmag_addsub_pipe #(
    parameter int MW = 24,
    parameter int GW = 2,
    localparam int W = MW + GW,
    localparam int LZW = $clog2(W + 2)
) (
    input  logic           clk,
    input  logic           res,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           op_sub,
    input  logic           a_sign,
    input  logic [W-1:0]   a_mag,
    input  logic           b_sign,
    input  logic [W-1:0]   b_mag,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_sign,
    output logic [W:0]     out_mag,
    output logic           out_zero,
    output logic [LZW-1:0] out_lzc
);

    // S1 state: ordered magnitudes plus the operation and sign they imply
    logic           r_s1_vld;
    logic           r_s1_eff_sub;
    logic           r_s1_sign;
    logic [W-1:0]   r_s1_big;
    logic [W-1:0]   r_s1_small;

    // S2 state: the registered result presented on out_*
    logic           r_s2_vld;
    logic           r_s2_sign;
    logic [W:0]     r_s2_mag;
    logic           r_s2_zero;
    logic [LZW-1:0] r_s2_lzc;

    logic           w_eb;
    logic           w_eff_sub;
    logic           w_a_gt;
    logic           w_eq;
    logic           w_sign;
    logic [W-1:0]   w_big;
    logic [W-1:0]   w_small;
    logic           w_s1_adv;
    logic [W:0]     w_sum;
    logic [LZW-1:0] w_lzc;

    // S1 can move into S2 whenever S2 is empty or being drained this cycle
    assign w_s1_adv = !r_s2_vld || out_ready;
    assign in_ready = !r_s1_vld || w_s1_adv;

    // Order operands by magnitude so S2 never has to produce a negative difference
    always_comb begin
        w_eb      = b_sign ^ op_sub;
        w_eff_sub = a_sign ^ w_eb;
        w_a_gt    = a_mag > b_mag;
        w_eq      = a_mag == b_mag;
        w_big     = a_mag;
        w_small   = b_mag;
        w_sign    = a_sign;
        if (w_eq) begin
            // x - x is +0; x + x keeps the common sign
            w_sign = w_eff_sub ? 1'b0 : a_sign;
        end else if (!w_a_gt) begin
            w_big   = b_mag;
            w_small = a_mag;
            w_sign  = w_eb;
        end
    end

    // S1 register: take a new beat on any accepting edge
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_s1_vld     <= 1'b0;
            r_s1_eff_sub <= 1'b0;
            r_s1_sign    <= 1'b0;
            r_s1_big     <= '0;
            r_s1_small   <= '0;
        end else begin
            if (in_ready) begin
                r_s1_vld <= in_valid;
            end
            if (in_valid && in_ready) begin
                r_s1_eff_sub <= w_eff_sub;
                r_s1_sign    <= w_sign;
                r_s1_big     <= w_big;
                r_s1_small   <= w_small;
            end
        end
    end

    // S2 arithmetic: full-width sum keeps the carry in bit W; big >= small so the difference is non-negative
    always_comb begin
        w_sum = r_s1_eff_sub ? ({1'b0, r_s1_big} - {1'b0, r_s1_small})
                             : ({1'b0, r_s1_big} + {1'b0, r_s1_small});
    end

    // Leading zeros counted from bit W; the highest set bit wins, all-zero gives W+1
    always_comb begin
        w_lzc = LZW'(W + 1);
        for (int i = 0; i <= W; i++) begin
            if (w_sum[i]) begin
                w_lzc = LZW'(W - i);
            end
        end
    end

    // S2 register: loads when S1 holds a beat and S2 is free or draining
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_s2_vld  <= 1'b0;
            r_s2_sign <= 1'b0;
            r_s2_mag  <= '0;
            r_s2_zero <= 1'b0;
            r_s2_lzc  <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s2_vld <= r_s1_vld;
            end
            if (r_s1_vld && w_s1_adv) begin
                r_s2_sign <= r_s1_sign;
                r_s2_mag  <= w_sum;
                r_s2_zero <= (w_sum == '0);
                r_s2_lzc  <= w_lzc;
            end
        end
    end

    assign out_valid = r_s2_vld;
    assign out_sign  = r_s2_sign;
    assign out_mag   = r_s2_mag;
    assign out_zero  = r_s2_zero;
    assign out_lzc   = r_s2_lzc;

endmodule

// File: tb/tb_fp_signmag_addsub_pipe.sv
// Directed and random checks of the two-stage sign-magnitude adder/subtractor.
// Two instances (MW=24/GW=2 and MW=53/GW=3) share stimulus; sel picks the one being exercised.
// Results are compared against hand-derived constants and a signed-integer reference model.
module tb_fp_signmag_addsub_pipe;

    typedef struct packed {
        logic        sign;
        logic [56:0] mag;
        logic        zero;
        logic [5:0]  lzc;
    } res_t;

    logic        clk = 1'b0;
    logic        res;
    logic        in_valid;
    logic        op_sub;
    logic        a_sign;
    logic        b_sign;
    logic        out_ready;
    logic [55:0] a_mag;
    logic [55:0] b_mag;
    logic        sel;

    logic        rdy24, vld24, sgn24, zero24;
    logic [26:0] mag24;
    logic [4:0]  lzc24;
    logic        rdy53, vld53, sgn53, zero53;
    logic [56:0] mag53;
    logic [5:0]  lzc53;

    res_t obs;
    logic obs_vld;
    logic obs_rdy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp_signmag_addsub_pipe #(.MW(24), .GW(2)) u_d24 (
        .clk(clk), .res(res), .in_valid(in_valid & ~sel), .in_ready(rdy24),
        .op_sub(op_sub), .a_sign(a_sign), .a_mag(a_mag[25:0]),
        .b_sign(b_sign), .b_mag(b_mag[25:0]),
        .out_valid(vld24), .out_ready(out_ready), .out_sign(sgn24),
        .out_mag(mag24), .out_zero(zero24), .out_lzc(lzc24)
    );

    fp_signmag_addsub_pipe #(.MW(53), .GW(3)) u_d53 (
        .clk(clk), .res(res), .in_valid(in_valid & sel), .in_ready(rdy53),
        .op_sub(op_sub), .a_sign(a_sign), .a_mag(a_mag),
        .b_sign(b_sign), .b_mag(b_mag),
        .out_valid(vld53), .out_ready(out_ready), .out_sign(sgn53),
        .out_mag(mag53), .out_zero(zero53), .out_lzc(lzc53)
    );

    always_comb begin
        obs_vld  = sel ? vld53 : vld24;
        obs_rdy  = sel ? rdy53 : rdy24;
        obs.sign = sel ? sgn53 : sgn24;
        obs.mag  = sel ? mag53 : {30'b0, mag24};
        obs.zero = sel ? zero53 : zero24;
        obs.lzc  = sel ? lzc53 : {1'b0, lzc24};
    end

    // Reference: signed integer sum of the two signed operands
    function automatic res_t model(int w, logic as, logic [55:0] am, logic bs, logic [55:0] bm, logic op);
        res_t   r;
        longint sa, sb, s;
        logic   eb;
        eb = bs ^ op;
        sa = longint'({8'h00, am});
        sb = longint'({8'h00, bm});
        if (as) sa = -sa;
        if (eb) sb = -sb;
        s = sa + sb;
        r.mag = 57'(s < 0 ? -s : s);
        if (s < 0)      r.sign = 1'b1;
        else if (s > 0) r.sign = 1'b0;
        else            r.sign = (as == eb) ? as : 1'b0;
        r.zero = (s == 0);
        r.lzc = 6'(w + 1);
        for (int i = 0; i <= w; i++) begin
            if (r.mag[i]) r.lzc = 6'(w - i);
        end
        return r;
    endfunction

    task automatic drive(logic v, logic as, logic [55:0] am, logic bs, logic [55:0] bm, logic op);
        in_valid = v;
        a_sign   = as;
        a_mag    = am;
        b_sign   = bs;
        b_mag    = bm;
        op_sub   = op;
    endtask

    // Issue one beat into an idle pipe; returns out_valid seen one cycle after acceptance,
    // and leaves time at the negedge where the result should be presented.
    task automatic send_wait2(logic as, logic [55:0] am, logic bs, logic [55:0] bm, logic op, output logic mid_vld);
        @(negedge clk);
        drive(1'b1, as, am, bs, bm, op);
        @(negedge clk);
        in_valid = 1'b0;
        mid_vld = obs_vld;
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            #1;
            total++;
            if (obs_vld !== 1'b0 || obs !== res_t'(0)) begin
                bad++;
                $display("FAIL reset sel=%0d vld=%b res=%h want vld=0 res=0", s, obs_vld, obs);
            end
        end
        @(negedge clk);
        res = 1'b1;
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            #1;
            total++;
            if (obs_rdy !== 1'b1) begin
                bad++;
                $display("FAIL reset_in_ready sel=%0d got=%b want 1", s, obs_rdy);
            end
        end
    endtask

    task automatic test_add_equal();
        for (int s = 0; s < 2; s++) begin
            int w; logic [55:0] h; res_t e; logic mid;
            sel = (s == 1);
            w = s ? 56 : 26;
            h = 56'd1 << (w - 1);
            send_wait2(1'b0, h, 1'b0, h, 1'b0, mid);
            e = '0;
            e.mag = 57'd1 << w;
            total++;
            if (mid !== 1'b0) begin
                bad++;
                $display("FAIL add_latency w=%0d out_valid=%b want 0", w, mid);
            end
            total++;
            if (obs_vld !== 1'b1 || obs !== e) begin
                bad++;
                $display("FAIL add_equal w=%0d vld=%b got=%h want=%h", w, obs_vld, obs, e);
            end
        end
    endtask

    task automatic test_sub_equal();
        for (int s = 0; s < 2; s++) begin
            int w; logic [55:0] h; res_t e; logic mid;
            sel = (s == 1);
            w = s ? 56 : 26;
            h = 56'd3 << (w - 2);
            send_wait2(1'b0, h, 1'b0, h, 1'b1, mid);
            e = '0;
            e.zero = 1'b1;
            e.lzc = 6'(w + 1);
            total++;
            if (obs_vld !== 1'b1 || obs !== e) begin
                bad++;
                $display("FAIL sub_equal w=%0d vld=%b got=%h want=%h", w, obs_vld, obs, e);
            end
        end
    endtask

    task automatic test_mixed_sign();
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 2; k++) begin
                int w; logic [55:0] h2, h3; res_t e; logic mid;
                sel = (s == 1);
                w = s ? 56 : 26;
                h2 = 56'd1 << (w - 1);
                h3 = 56'd3 << (w - 2);
                if (k == 0) send_wait2(1'b1, h2, 1'b0, h3, 1'b0, mid);
                else        send_wait2(1'b0, h3, 1'b1, h2, 1'b0, mid);
                e = '0;
                e.mag = 57'd1 << (w - 2);
                e.lzc = 6'd2;
                total++;
                if (obs_vld !== 1'b1 || obs !== e) begin
                    bad++;
                    $display("FAIL mixed_sign w=%0d order=%0d vld=%b got=%h want=%h", w, k, obs_vld, obs, e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [55:0] am[8];
        logic [55:0] bm[8];
        logic        as[8], bs[8], op[8];
        res_t q[$];
        res_t held, e;
        int   idx, got;
        logic acc, exp_rdy;
        idx = 0;
        got = 0;
        held = '0;
        sel = 1'b0;
        for (int i = 0; i < 8; i++) begin
            am[i] = 56'($urandom() & 32'h03ff_ffff);
            bm[i] = (i == 5) ? am[i] : 56'($urandom() & 32'h03ff_ffff);
            as[i] = 1'($urandom_range(0, 1));
            bs[i] = 1'($urandom_range(0, 1));
            op[i] = 1'(i & 1);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 6);
            if (idx < 8) drive(1'b1, as[idx], am[idx], bs[idx], bm[idx], op[idx]);
            else         in_valid = 1'b0;
            #1;
            exp_rdy = !(c >= 3 && c <= 6);
            total++;
            if (obs_rdy !== exp_rdy) begin
                bad++;
                $display("FAIL b2b_in_ready cycle=%0d got=%b want=%b", c, obs_rdy, exp_rdy);
            end
            if (c == 3) held = obs;
            if (c >= 4 && c <= 6) begin
                total++;
                if (obs_vld !== 1'b1 || obs !== held) begin
                    bad++;
                    $display("FAIL b2b_stall cycle=%0d vld=%b got=%h want=%h", c, obs_vld, obs, held);
                end
            end
            if (obs_vld && out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_extra cycle=%0d got=%h want no beat", c, obs);
                end else begin
                    e = q.pop_front();
                    got++;
                    if (obs !== e) begin
                        bad++;
                        $display("FAIL b2b_data beat=%0d got=%h want=%h", got - 1, obs, e);
                    end
                end
            end
            acc = in_valid && obs_rdy;
            if (acc) q.push_back(model(26, as[idx], am[idx], bs[idx], bm[idx], op[idx]));
            @(posedge clk);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        total++;
        if (got != 8 || idx != 8) begin
            bad++;
            $display("FAIL b2b_count got=%0d sent=%0d want 8/8", got, idx);
        end
    endtask

    task automatic test_reset_midflight();
        res_t e;
        sel = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        drive(1'b1, 1'b0, 56'h0123456, 1'b0, 56'h0654321, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 56'h1000000, 1'b0, 56'h0000001, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (obs_vld !== 1'b1) begin
            bad++;
            $display("FAIL rst_inflight out_valid=%b want 1", obs_vld);
        end
        #2 res = 1'b0;
        #1;
        total++;
        if (obs_vld !== 1'b0 || obs.mag !== 57'd0) begin
            bad++;
            $display("FAIL rst_async vld=%b mag=%h want vld=0 mag=0", obs_vld, obs.mag);
        end
        @(negedge clk);
        res = 1'b1;
        drive(1'b1, 1'b0, 56'h2000000, 1'b1, 56'h0800000, 1'b0);
        #1;
        total++;
        if (obs_rdy !== 1'b1) begin
            bad++;
            $display("FAIL rst_release_ready got=%b want 1", obs_rdy);
        end
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (obs_vld !== 1'b0) begin
            bad++;
            $display("FAIL rst_no_stale1 out_valid=%b want 0", obs_vld);
        end
        @(negedge clk);
        e = '0;
        e.mag = 57'h1800000;
        e.lzc = 6'd2;
        total++;
        if (obs_vld !== 1'b1 || obs !== e) begin
            bad++;
            $display("FAIL rst_new_beat vld=%b got=%h want=%h", obs_vld, obs, e);
        end
        @(negedge clk);
        total++;
        if (obs_vld !== 1'b0) begin
            bad++;
            $display("FAIL rst_no_stale2 out_valid=%b want 0", obs_vld);
        end
    endtask

    task automatic test_random();
        localparam int N = 10000;
        res_t q[$];
        res_t e;
        int   sent, got, cyc;
        logic have, acc;
        logic as, bs, op;
        logic [55:0] am, bm;
        sent = 0; got = 0; cyc = 0; have = 1'b0;
        as = 1'b0; bs = 1'b0; op = 1'b0; am = '0; bm = '0;
        sel = 1'b1;
        while (got < N && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!have && sent < N) begin
                am = 56'({$urandom(), $urandom()});
                bm = ($urandom_range(0, 15) == 0) ? am : 56'({$urandom(), $urandom()});
                as = 1'($urandom_range(0, 1));
                bs = 1'($urandom_range(0, 1));
                op = 1'($urandom_range(0, 1));
                have = ($urandom_range(0, 7) != 0);
            end
            drive(have, as, am, bs, bm, op);
            #1;
            if (obs_vld && out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL rand_extra cycle=%0d got=%h want no beat", cyc, obs);
                end else begin
                    e = q.pop_front();
                    got++;
                    if (obs !== e) begin
                        bad++;
                        $display("FAIL rand_data beat=%0d got=%h want=%h", got - 1, obs, e);
                    end
                end
            end
            acc = in_valid && obs_rdy;
            if (acc) q.push_back(model(56, as, am, bs, bm, op));
            @(posedge clk);
            if (acc) begin
                have = 1'b0;
                sent++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        total++;
        if (got != N) begin
            bad++;
            $display("FAIL rand_count got=%0d want %0d after %0d cycles", got, N, cyc);
        end
    endtask

    initial begin
        sel = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        res = 1'b1;
        #2 res = 1'b0;
        test_reset();
        test_add_equal();
        test_sub_equal();
        test_mixed_sign();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
